// File: rtl/gigatron_input_pkg.sv
// Shared constants for the Gigatron input path: sync bit positions, idle value, button bit map.
package gigatron_io_pkg;

  localparam int HSYNC_BIT_DEFAULT   = 6;
  localparam int VSYNC_BIT_DEFAULT   = 7;
  localparam int SYNC_STAGES_DEFAULT = 2;
  localparam logic [7:0] IDLE_VALUE_DEFAULT = 8'hFF;

  // Button positions within the active-low button byte (MSB leaves the controller first).
  localparam int BTN_RIGHT  = 0;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_UP     = 3;
  localparam int BTN_START  = 4;
  localparam int BTN_SELECT = 5;
  localparam int BTN_B      = 6;
  localparam int BTN_A      = 7;

  typedef logic [7:0] byte_t;

  function automatic logic edge_rise(input logic prev_level, input logic cur_level);
    return !prev_level && cur_level;
  endfunction

endpackage

// File: rtl/gigatron_input_if.sv
// Bus between the core-side test top and gigatron_input. INPUT_OVERRIDE_EN adds the force pins.
interface gigatron_input_if;
  import gigatron_io_pkg::*;

  byte_t i_out;
  byte_t i_buttons;
  byte_t o_in;
  logic  o_serial;
  logic  o_frame;
`ifdef INPUT_OVERRIDE_EN
  logic  i_force;
  byte_t i_force_data;
`endif

  modport master (
    output i_out,
    output i_buttons,
`ifdef INPUT_OVERRIDE_EN
    output i_force,
    output i_force_data,
`endif
    input  o_in,
    input  o_serial,
    input  o_frame
  );

  modport slave (
    input  i_out,
    input  i_buttons,
`ifdef INPUT_OVERRIDE_EN
    input  i_force,
    input  i_force_data,
`endif
    output o_in,
    output o_serial,
    output o_frame
  );

endinterface

// File: rtl/gigatron_input_sync.sv
// N-stage 8-bit synchronizer for the asynchronous button lines; resets to all-released (8'hFF).
module gigatron_sync #(
  parameter int STAGES = 2
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [7:0] i_d,
  output logic [7:0] o_q
);

  logic [7:0] chain_q [STAGES];

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < STAGES; i++) chain_q[i] <= 8'hFF;
    end else begin
      chain_q[0] <= i_d;
      for (int i = 1; i < STAGES; i++) chain_q[i] <= chain_q[i-1];
    end
  end

  assign o_q = chain_q[STAGES-1];

endmodule

// File: rtl/gigatron_input.sv
// Controller (4021) shift register, board deserializer and latch driving the core IN port.
// Optional INPUT_OVERRIDE_EN adds a combinational force path onto o_in.
module gigatron_input
  import gigatron_io_pkg::*;
#(
  parameter int          HSYNC_BIT   = HSYNC_BIT_DEFAULT,
  parameter int          VSYNC_BIT   = VSYNC_BIT_DEFAULT,
  parameter int          SYNC_STAGES = SYNC_STAGES_DEFAULT,  // legal 1..4
  parameter logic [7:0]  IDLE_VALUE  = IDLE_VALUE_DEFAULT
) (
  input logic             i_clock,
  input logic             i_reset,
  gigatron_input_if.slave bus
);

  byte_t out_q;
  byte_t btn_s;
  byte_t ctrl_sr_q, ctrl_sr_d;
  byte_t rx_sr_q, rx_sr_d;
  byte_t latch_q, latch_d;
  logic  frame_q, frame_d;
  logic  hs_rise, vs_rise, ctrl_load;

  gigatron_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_d     (bus.i_buttons),
    .o_q     (btn_s)
  );

  always_comb begin
    hs_rise   = edge_rise(out_q[HSYNC_BIT], bus.i_out[HSYNC_BIT]);
    vs_rise   = edge_rise(out_q[VSYNC_BIT], bus.i_out[VSYNC_BIT]);
    // The registered VSYNC is still low on the rising cycle, so loading wins over a coincident shift.
    ctrl_load = !bus.i_out[VSYNC_BIT] || !out_q[VSYNC_BIT];

    ctrl_sr_d = ctrl_sr_q;
    rx_sr_d   = rx_sr_q;
    latch_d   = latch_q;
    frame_d   = 1'b0;

    if (ctrl_load)
      ctrl_sr_d = btn_s;
    else if (hs_rise)
      ctrl_sr_d = {ctrl_sr_q[6:0], 1'b1};

    if (hs_rise)
      rx_sr_d = {rx_sr_q[6:0], ctrl_sr_q[7]};

    if (vs_rise) begin
      latch_d = rx_sr_q;
      frame_d = 1'b1;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      out_q     <= 8'hFF;
      ctrl_sr_q <= IDLE_VALUE;
      rx_sr_q   <= IDLE_VALUE;
      latch_q   <= IDLE_VALUE;
      frame_q   <= 1'b0;
    end else begin
      out_q     <= bus.i_out;
      ctrl_sr_q <= ctrl_sr_d;
      rx_sr_q   <= rx_sr_d;
      latch_q   <= latch_d;
      frame_q   <= frame_d;
    end
  end

  assign bus.o_serial = ctrl_sr_q[7];

`ifdef INPUT_OVERRIDE_EN
  assign bus.o_in    = bus.i_force ? bus.i_force_data : latch_q;
  assign bus.o_frame = frame_q && !bus.i_force;
`else
  assign bus.o_in    = latch_q;
  assign bus.o_frame = frame_q;
`endif

endmodule

// File: tb/tb_gigatron_input.sv
// Randomized frame-level bench for gigatron_input; define INPUT_OVERRIDE_EN to also exercise the force path.
module tb_gigatron_input;
  import gigatron_io_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gigatron_input_if bus();

  gigatron_input dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int    errors = 0;
  int    checks = 0;
  byte_t m_rx;        // expected deserializer contents
  byte_t m_lat;       // expected latched value
  bit    forcing = 1'b0;
  byte_t force_val = 8'hA5;
  int    frame_no = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hs_pulse();
    bus.i_out[HSYNC_BIT_DEFAULT] = 1'b0;
    tick();
    bus.i_out[HSYNC_BIT_DEFAULT] = 1'b1;
    tick();
  endtask

  // One VSYNC low period (loads btn), the rising edge (latches the previous frame), then nhs HSYNC pulses.
  task automatic run_frame(input byte_t btn, input int nlow, input int nhs,
                           input bit late, input byte_t late_btn);
    logic [31:0] stream;
    bus.i_buttons = btn;
    bus.i_out[5:0] = 6'($urandom);
    repeat (4) tick();
    bus.i_out[VSYNC_BIT_DEFAULT] = 1'b0;
    tick();
    tick();
    check_eq("serial_load", {7'b0, bus.o_serial}, {7'b0, btn[7]});
    for (int i = 0; i < nlow; i++) begin
      hs_pulse();
      m_rx = {m_rx[6:0], btn[7]};
    end
    if (late) bus.i_buttons = late_btn;
    tick();
    bus.i_out[VSYNC_BIT_DEFAULT] = 1'b1;
    tick();
    m_lat = m_rx;
    if (forcing) begin
      check_eq("in_forced", bus.o_in, force_val);
      check_eq("frame_forced", {7'b0, bus.o_frame}, 8'h00);
    end else begin
      check_eq("in_latch", bus.o_in, m_lat);
      check_eq("frame_pulse", {7'b0, bus.o_frame}, 8'h01);
    end
    tick();
    check_eq("frame_end", {7'b0, bus.o_frame}, 8'h00);
    for (int i = 0; i < nhs; i++) hs_pulse();
    stream = {m_rx, btn, 16'hFFFF} << nhs;
    m_rx = stream[31:24];
    $display("frame %0d btn=%02h low_hs=%0d hs=%0d late=%0d o_in=%02h next_rx=%02h",
             frame_no, btn, nlow, nhs, late, bus.o_in, m_rx);
    frame_no++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.i_out     = 8'hFF;
    bus.i_buttons = 8'hFF;
`ifdef INPUT_OVERRIDE_EN
    bus.i_force      = 1'b0;
    bus.i_force_data = 8'h00;
`endif
    m_rx  = 8'hFF;
    m_lat = 8'hFF;
    repeat (3) tick();
    check_eq("rst_in", bus.o_in, 8'hFF);
    check_eq("rst_serial", {7'b0, bus.o_serial}, 8'h01);
    check_eq("rst_frame", {7'b0, bus.o_frame}, 8'h00);
    rst = 1'b0;
    tick();

    // Reset in the middle of a frame with a partially filled deserializer.
    bus.i_buttons = 8'h12;
    repeat (4) tick();
    bus.i_out[VSYNC_BIT_DEFAULT] = 1'b0;
    tick();
    bus.i_out[VSYNC_BIT_DEFAULT] = 1'b1;
    tick();
    repeat (3) hs_pulse();
    rst = 1'b1;
    bus.i_out = 8'hFF;
    tick();
    rst = 1'b0;
    tick();
    check_eq("midrst_in", bus.o_in, 8'hFF);
    check_eq("midrst_serial", {7'b0, bus.o_serial}, 8'h01);
    check_eq("midrst_frame", {7'b0, bus.o_frame}, 8'h00);
    $display("reset mid-frame o_in=%02h serial=%0d", bus.o_in, bus.o_serial);
    m_rx  = 8'hFF;
    m_lat = 8'hFF;

    // Directed frames: full, short, long, and a late button change.
    run_frame(8'h7E, 0, 8,  1'b0, 8'h00);
    run_frame(8'hFF, 0, 8,  1'b0, 8'h00);   // latches 7E
    run_frame(8'h7E, 0, 5,  1'b0, 8'h00);   // latches FF
    run_frame(8'h7E, 0, 10, 1'b0, 8'h00);   // latches EF
    run_frame(8'hFF, 0, 8,  1'b1, 8'h00);   // latches FB; old FF loaded despite the late change
    run_frame(8'h00, 0, 8,  1'b0, 8'h00);   // latches FF
    run_frame(8'hFF, 0, 8,  1'b0, 8'h00);   // latches 00

    for (int n = 0; n < 14; n++)
      run_frame(byte_t'($urandom), $urandom_range(0, 2), $urandom_range(0, 12), 1'b0, 8'h00);

`ifdef INPUT_OVERRIDE_EN
    forcing = 1'b1;
    bus.i_force_data = force_val;
    bus.i_force = 1'b1;
    #1;
    check_eq("force_now", bus.o_in, force_val);
    run_frame(8'h3C, 0, 8, 1'b0, 8'h00);
    run_frame(8'hFF, 0, 0, 1'b0, 8'h00);   // latches 3C underneath the force
    bus.i_force = 1'b0;
    forcing = 1'b0;
    #1;
    check_eq("force_release", bus.o_in, m_lat);
    check_eq("force_release_v", bus.o_in, 8'h3C);
    $display("force released o_in=%02h", bus.o_in);
    run_frame(8'h5A, 1, 8, 1'b0, 8'h00);
`endif

    run_frame(8'hFF, 0, 0, 1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
